// File: rtl/dift_trap_ctrl_pkg.sv
// Shared DIFT trap controller definitions: trap types, FSM encodings,
// CSR indices and CAUSE word bit positions.
package dift_trap_ctrl_pkg;

  typedef logic [2:0] dift_trap_t;

  localparam dift_trap_t DIFT_TRAP_TYPE_EXEC = 3'd0;
  localparam dift_trap_t DIFT_TRAP_TYPE_STOR = 3'd1;
  localparam dift_trap_t DIFT_TRAP_TYPE_LOAD = 3'd2;
  localparam dift_trap_t DIFT_TRAP_TYPE_JALR = 3'd3;
  localparam dift_trap_t DIFT_TRAP_TYPE_BRAN = 3'd4;

  typedef logic [1:0] dift_trapctrl_state_t;

  localparam dift_trapctrl_state_t TC_IDLE    = 2'd0;
  localparam dift_trapctrl_state_t TC_PEND    = 2'd1;
  localparam dift_trapctrl_state_t TC_HANDLER = 2'd2;

  localparam logic [1:0] DIFT_TRAPCSR_CAUSE = 2'd0;
  localparam logic [1:0] DIFT_TRAPCSR_TPC   = 2'd1;
  localparam logic [1:0] DIFT_TRAPCSR_TINSN = 2'd2;
  localparam logic [1:0] DIFT_TRAPCSR_TCNT  = 2'd3;

  localparam int CAUSE_VALID_BIT = 8;
  localparam int CAUSE_OVF_BIT   = 9;

endpackage

// File: rtl/dift_trap_ctrl_sat_counter.sv
// Saturating up-counter; a clear in the same cycle as an increment yields 1.
module dift_sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc_i,
  input  logic                 clr_i,
  output logic [CNT_WIDTH-1:0] cnt_o
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = inc_i ? {{(CNT_WIDTH-1){1'b0}}, 1'b1} : '0;
    else if (inc_i && (cnt_q != {CNT_WIDTH{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/dift_trap_ctrl.sv
// DIFT trap controller: captures accepted tag-check traps, holds a request
// to the core until acked, blocks nesting until mret, exposes CSR reads.
module dift_trap_ctrl
  import dift_trap_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH  = 16,
  parameter int TYPE_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trap_en_i,
  input  logic                  trap_i,
  input  logic [TYPE_WIDTH-1:0] trap_type_i,
  input  logic [31:0]           pc_i,
  input  logic [31:0]           instr_i,
  input  logic                  trap_ack_i,
  input  logic                  mret_i,
  input  logic [1:0]            csr_addr_i,
  input  logic                  csr_clr_i,
  output logic                  trap_req_o,
  output logic [TYPE_WIDTH-1:0] trap_cause_o,
  output logic [31:0]           trap_pc_o,
  output logic [31:0]           csr_rdata_o
);

  dift_trapctrl_state_t  state_q, state_d;
  logic [TYPE_WIDTH-1:0] type_q;
  logic [31:0]           pc_q, instr_q;
  logic                  valid_q, ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  trap_v, accept, drop;
  logic [31:0]           cause_w, tcnt_w;

  assign trap_v = trap_en_i & trap_i;
  // mret frees the handler slot in the same cycle, so a new trap may land then
  assign accept = trap_v & ((state_q == TC_IDLE) | ((state_q == TC_HANDLER) & mret_i));
  assign drop   = trap_v & ((state_q == TC_PEND) | ((state_q == TC_HANDLER) & ~mret_i));

  always_comb begin
    state_d = state_q;
    case (state_q)
      TC_IDLE:    if (accept)     state_d = TC_PEND;
      TC_PEND:    if (trap_ack_i) state_d = TC_HANDLER;
      TC_HANDLER: if (mret_i)     state_d = accept ? TC_PEND : TC_IDLE;
      default:                    state_d = TC_IDLE;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (csr_clr_i) ovf_d = 1'b0;
    else if (drop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TC_IDLE;
      type_q  <= '0;
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
      if (accept) begin
        type_q  <= trap_type_i;
        pc_q    <= pc_i;
        instr_q <= instr_i;
        valid_q <= 1'b1;
      end
    end
  end

  dift_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (accept),
    .clr_i (csr_clr_i),
    .cnt_o (cnt)
  );

  always_comb begin
    cause_w                  = '0;
    cause_w[TYPE_WIDTH-1:0]  = type_q;
    cause_w[CAUSE_VALID_BIT] = valid_q;
    cause_w[CAUSE_OVF_BIT]   = ovf_q;
    cause_w[31:30]           = state_q;
    tcnt_w                   = '0;
    tcnt_w[CNT_WIDTH-1:0]    = cnt;
  end

  always_comb begin
    case (csr_addr_i)
      DIFT_TRAPCSR_CAUSE: csr_rdata_o = cause_w;
      DIFT_TRAPCSR_TPC:   csr_rdata_o = pc_q;
      DIFT_TRAPCSR_TINSN: csr_rdata_o = instr_q;
      default:            csr_rdata_o = tcnt_w;
    endcase
  end

  assign trap_req_o   = (state_q == TC_PEND);
  assign trap_cause_o = type_q;
  assign trap_pc_o    = pc_q;

endmodule
